// File: rtl/seg_display_if.sv
// seg_display_if: bundles the requester inputs (base view, note view,
// transient message) and the registered digit codes / busy flag of the
// 8-digit seven-segment display arbiter.
// Digit i of every 48-bit view is bits [6i+5:6i].
interface seg_display_if;
  logic [47:0] base_data;
  logic        note_valid;
  logic [47:0] note_data;
  logic        msg_valid;
  logic [47:0] msg_data;
  logic        msg_cancel;
  logic [5:0]  p0;
  logic [5:0]  p1;
  logic [5:0]  p2;
  logic [5:0]  p3;
  logic [5:0]  p4;
  logic [5:0]  p5;
  logic [5:0]  p6;
  logic [5:0]  p7;
  logic        busy;

  // Requester side: drives the views, observes the scanner codes.
  modport master (
    output base_data, note_valid, note_data, msg_valid, msg_data, msg_cancel,
    input  p0, p1, p2, p3, p4, p5, p6, p7, busy
  );

  // Arbiter side.
  modport slave (
    input  base_data, note_valid, note_data, msg_valid, msg_data, msg_cancel,
    output p0, p1, p2, p3, p4, p5, p6, p7, busy
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: owns the eight 6-bit digit codes feeding the
// seven-segment scanner and shares them between a timed transient message
// (highest priority), a level-requested note view and the base view.
// Optional feature macro: SEG_SCROLL_EN -- when defined, the message scrolls
// one digit every SCROLL_TICKS ticks; when undefined it is shown static.
// Outputs are registered from the next-state view, so a request seen at a
// clock edge is visible right after that edge.
module seg_display_arbiter #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned HOLD_TICKS   = 2000,
  parameter int unsigned SCROLL_TICKS = 250,
  parameter logic [5:0]  BLANK_CODE   = 6'h3F
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_display_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    S_BASE = 2'd0,
    S_NOTE = 2'd1,
    S_MSG  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [HW-1:0] hold_cnt_q;
  logic [HW-1:0] hold_cnt_d;
  logic [47:0]   msg_q;
  logic [47:0]   msg_d;
  logic [2:0]    scroll_pos_d;
  logic [47:0]   disp_q;
  logic [47:0]   disp_d;
  logic          busy_q;

  // Digit i of the result is digit (i+pos) mod 8 of the input, i.e. the
  // message shifted left on the display by pos positions.
  function automatic logic [47:0] rotate_digits(input logic [47:0] d,
                                                input logic [2:0]  pos);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[6*i +: 6] = d[6*((i + int'(pos)) % 8) +: 6];
    end
    return r;
  endfunction

  // Free-running tick prescaler; tick is high for the last count of a period.
  assign tick = (tick_cnt_q == TICK_LAST);

  // Tick prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // Next-state, hold counter and message latch; a new message always wins,
  // even over a cancel in the same cycle.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    msg_d      = msg_q;
    if (bus.msg_valid) begin
      state_d    = S_MSG;
      msg_d      = bus.msg_data;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        S_MSG: begin
          if (bus.msg_cancel) begin
            state_d = bus.note_valid ? S_NOTE : S_BASE;
          end else if (tick) begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_d = bus.note_valid ? S_NOTE : S_BASE;
            end else begin
              hold_cnt_d = hold_cnt_q + HW'(1);
            end
          end
        end
        default: begin
          state_d = bus.note_valid ? S_NOTE : S_BASE;
        end
      endcase
    end
  end

  // FSM state, hold counter and message latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BASE;
      hold_cnt_q <= '0;
      msg_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      msg_q      <= msg_d;
    end
  end

`ifdef SEG_SCROLL_EN
  localparam int SW = $clog2(SCROLL_TICKS + 1);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_TICKS - 1);

  logic [SW-1:0] scroll_cnt_q;
  logic [SW-1:0] scroll_cnt_d;
  logic [2:0]    scroll_pos_q;

  // Scroll step timing runs alongside the hold count and never delays exit.
  always_comb begin
    scroll_cnt_d = scroll_cnt_q;
    scroll_pos_d = scroll_pos_q;
    if (bus.msg_valid) begin
      scroll_cnt_d = '0;
      scroll_pos_d = '0;
    end else if ((state_q == S_MSG) && tick) begin
      if (scroll_cnt_q == SCROLL_LAST) begin
        scroll_cnt_d = '0;
        scroll_pos_d = scroll_pos_q + 3'd1;
      end else begin
        scroll_cnt_d = scroll_cnt_q + SW'(1);
      end
    end
  end

  // Scroll counter and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_cnt_q <= '0;
      scroll_pos_q <= '0;
    end else begin
      scroll_cnt_q <= scroll_cnt_d;
      scroll_pos_q <= scroll_pos_d;
    end
  end
`else
  // Static message: always shown from digit 0.
  assign scroll_pos_d = 3'd0;
`endif

  // Select the view belonging to the next state.
  always_comb begin
    disp_d = bus.base_data;
    case (state_d)
      S_MSG:   disp_d = rotate_digits(msg_d, scroll_pos_d);
      S_NOTE:  disp_d = bus.note_data;
      default: disp_d = bus.base_data;
    endcase
  end

  // Registered digit codes and busy flag; blank display while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= {8{BLANK_CODE}};
      busy_q <= 1'b0;
    end else begin
      disp_q <= disp_d;
      busy_q <= (state_d == S_MSG);
    end
  end

  assign bus.p0   = disp_q[5:0];
  assign bus.p1   = disp_q[11:6];
  assign bus.p2   = disp_q[17:12];
  assign bus.p3   = disp_q[23:18];
  assign bus.p4   = disp_q[29:24];
  assign bus.p5   = disp_q[35:30];
  assign bus.p6   = disp_q[41:36];
  assign bus.p7   = disp_q[47:42];
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: table-driven vectors for the base/note views,
// hand-written message sequences (hold length, retrigger, cancel, async
// reset, scrolling) and a randomized run, all checked against a
// message-lifetime reference model. Honours SEG_SCROLL_EN like the design.
`timescale 1ns/1ps
module tb_seg_display_arbiter;
  localparam int TICK_DIV = 4;
  localparam int HOLD     = 3;
  localparam int SCROLL   = 1;
  localparam logic [5:0] BLANK = 6'h3F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_display_if bus();

  seg_display_arbiter #(
    .TICK_DIV    (TICK_DIV),
    .HOLD_TICKS  (HOLD),
    .SCROLL_TICKS(SCROLL),
    .BLANK_CODE  (BLANK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: message alive flag, ticks elapsed since acceptance.
  int          m_edge;
  bit          m_on;
  logic [47:0] m_msg;
  int          m_ticks;
  logic [47:0] m_disp;
  logic        m_busy;

  typedef struct {
    logic        nv;
    logic [47:0] nd;
    logic [47:0] bd;
    logic [47:0] exp;
  } vec_t;

  function automatic logic [47:0] fill(input logic [5:0] c);
    return {8{c}};
  endfunction

  function automatic logic [47:0] seq_digits(input int first);
    logic [47:0] r;
    for (int i = 0; i < 8; i++) r[6*i +: 6] = 6'(first + i);
    return r;
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  function automatic logic [47:0] shown(input logic [47:0] d, input int pos);
    logic [5:0]  dg [8];
    logic [47:0] r;
    for (int i = 0; i < 8; i++) dg[i] = d[6*i +: 6];
    for (int i = 0; i < 8; i++) r[6*i +: 6] = dg[(i + pos) % 8];
    return r;
  endfunction

  function automatic logic [47:0] dut_disp();
    return {bus.p7, bus.p6, bus.p5, bus.p4, bus.p3, bus.p2, bus.p1, bus.p0};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edge  = 0;
    m_on    = 0;
    m_msg   = '0;
    m_ticks = 0;
    m_disp  = fill(BLANK);
    m_busy  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present now.
  task automatic model_step();
    bit tk;
    int pos;
    tk = ((m_edge % TICK_DIV) == TICK_DIV - 1);
    if (bus.msg_valid) begin
      m_on    = 1;
      m_msg   = bus.msg_data;
      m_ticks = 0;
    end else if (m_on) begin
      if (bus.msg_cancel) m_on = 0;
      else if (tk) begin
        m_ticks++;
        if (m_ticks == HOLD) m_on = 0;
      end
    end
    m_edge++;
`ifdef SEG_SCROLL_EN
    pos = (m_ticks / SCROLL) % 8;
`else
    pos = 0;
`endif
    if (m_on)                m_disp = shown(m_msg, pos);
    else if (bus.note_valid) m_disp = bus.note_data;
    else                     m_disp = bus.base_data;
    m_busy = m_on;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("model_disp", dut_disp(), m_disp);
    chk("model_busy", {47'd0, bus.busy}, {47'd0, m_busy});
  endtask

  // Run until busy drops (bounded); returns edges since the accept edge.
  task automatic wait_idle(output int k);
    k = 0;
    do begin
      cycle();
      k++;
    end while (bus.busy && k < 20);
  endtask

  task automatic chk_range(input string name, input int v, input int lo, input int hi);
    total++;
    if (v < lo || v > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic send_msg(input logic [47:0] d, input logic cancel);
    bus.msg_valid  = 1'b1;
    bus.msg_data   = d;
    bus.msg_cancel = cancel;
    cycle();
    bus.msg_valid  = 1'b0;
    bus.msg_cancel = 1'b0;
  endtask

  vec_t tbl [6];
  int   k;

  initial begin
    bus.base_data  = seq_digits(0);
    bus.note_valid = 1'b0;
    bus.note_data  = '0;
    bus.msg_valid  = 1'b0;
    bus.msg_data   = '0;
    bus.msg_cancel = 1'b0;
    model_reset();

    // Reset state, then release.
    #12;
    chk("rst_disp", dut_disp(), fill(BLANK));
    chk("rst_busy", {47'd0, bus.busy}, 48'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_disp", dut_disp(), fill(BLANK));
    rst_n = 1'b1;
    model_reset();
    cycle();
    chk("rst_release", dut_disp(), seq_digits(0));

    // Base / note views.
    tbl[0] = '{nv: 1'b1, nd: fill(6'h0A),    bd: seq_digits(0), exp: fill(6'h0A)};
    tbl[1] = '{nv: 1'b0, nd: fill(6'h0A),    bd: seq_digits(0), exp: seq_digits(0)};
    tbl[2] = '{nv: 1'b1, nd: seq_digits(8),  bd: seq_digits(0), exp: seq_digits(8)};
    tbl[3] = '{nv: 1'b0, nd: seq_digits(8),  bd: fill(6'h05),   exp: fill(6'h05)};
    tbl[4] = '{nv: 1'b1, nd: seq_digits(40), bd: fill(6'h05),   exp: seq_digits(40)};
    tbl[5] = '{nv: 1'b0, nd: fill(6'h0A),    bd: seq_digits(0), exp: seq_digits(0)};
    for (int i = 0; i < 6; i++) begin
      bus.note_valid = tbl[i].nv;
      bus.note_data  = tbl[i].nd;
      bus.base_data  = tbl[i].bd;
      cycle();
      chk($sformatf("tbl%0d_disp", i), dut_disp(), tbl[i].exp);
      chk($sformatf("tbl%0d_busy", i), {47'd0, bus.busy}, 48'd0);
    end

    // Cancel with no message showing is ignored.
    bus.msg_cancel = 1'b1;
    cycle();
    bus.msg_cancel = 1'b0;
    chk("idle_cancel", dut_disp(), seq_digits(0));

    // Message accept, hold length, return to note view.
    bus.note_valid = 1'b1;
    bus.note_data  = fill(6'h0A);
    send_msg(fill(6'h11), 1'b0);
    chk("msg_disp", dut_disp(), fill(6'h11));
    chk("msg_busy", {47'd0, bus.busy}, 48'd1);
    wait_idle(k);
    chk_range("hold_len", k, 8, 12);
    chk("msg_exit_note", dut_disp(), fill(6'h0A));

    // Retrigger restarts the full hold.
    bus.note_valid = 1'b0;
    send_msg(fill(6'h11), 1'b0);
    for (int i = 0; i < 8; i++) cycle();
    send_msg(fill(6'h22), 1'b0);
    chk("retrig_disp", dut_disp(), fill(6'h22));
    wait_idle(k);
    chk_range("retrig_len", k, 8, 12);
    chk("retrig_exit", dut_disp(), seq_digits(0));

    // New message and cancel together: message wins; lone cancel exits.
    send_msg(fill(6'h33), 1'b0);
    cycle();
    send_msg(fill(6'h24), 1'b1);
    chk("vld_cancel_busy", {47'd0, bus.busy}, 48'd1);
    chk("vld_cancel_disp", dut_disp(), fill(6'h24));
    bus.msg_cancel = 1'b1;
    cycle();
    bus.msg_cancel = 1'b0;
    chk("cancel_busy", {47'd0, bus.busy}, 48'd0);
    chk("cancel_disp", dut_disp(), seq_digits(0));

    // Scrolling: after exactly one tick p0 shows digit 1 (or stays 0).
    send_msg(seq_digits(0), 1'b0);
    chk("scroll_start", {42'd0, bus.p0}, 48'd0);
    for (int i = 0; i < 4; i++) cycle();
`ifdef SEG_SCROLL_EN
    chk("scroll_p0", {42'd0, bus.p0}, 48'd1);
`else
    chk("scroll_p0", {42'd0, bus.p0}, 48'd0);
`endif
    wait_idle(k);

    // Asynchronous reset in the middle of a message.
    send_msg(fill(6'h11), 1'b0);
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_disp", dut_disp(), fill(BLANK));
    chk("arst_busy", {47'd0, bus.busy}, 48'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle();
    chk("arst_release", dut_disp(), seq_digits(0));
    chk("arst_rel_busy", {47'd0, bus.busy}, 48'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) bus.note_valid = ~bus.note_valid;
      if ($urandom_range(5) == 0) bus.note_data = rnd48();
      if ($urandom_range(9) == 0) bus.base_data = rnd48();
      bus.msg_valid  = ($urandom_range(15) == 0);
      bus.msg_data   = rnd48();
      bus.msg_cancel = ($urandom_range(11) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
